// File: rtl/modmul_datapath.sv
// Iterative modular multiplier datapath: R = (A * B) mod M, MSB-first interleaved
// multiply/reduce, responding to the modular-multiply controller handshake.
module modmul_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] op_m,
    input  logic             initialize,
    input  logic             en_multiply,
    input  logic             en_modulo,
    input  logic             done,
    output logic             is_init_done,
    output logic             is_multiplication_done,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             mod_error
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_REDUCE = 2'd1,
        PH_READY  = 2'd2
    } phase_t;

    phase_t             phase, phase_nxt;
    logic [WIDTH-1:0]   a_reg, a_reg_nxt;
    logic [WIDTH-1:0]   b_reg, b_reg_nxt;
    logic [WIDTH-1:0]   m_reg, m_reg_nxt;
    logic [WIDTH:0]     rem, rem_nxt;
    logic [WIDTH+1:0]   acc, acc_nxt;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_nxt;
    logic [CNT_W-1:0]   red_cnt, red_cnt_nxt;
    logic               init_done_nxt;
    logic [WIDTH-1:0]   result_nxt;
    logic               result_valid_nxt;
    logic               mod_error_nxt;
    logic [WIDTH:0]     rem_sub;
    logic [WIDTH+1:0]   acc_mul;
    logic [WIDTH+1:0]   acc_mod;

    // One restoring-division step: bring in the next dividend bit, subtract M if it fits.
    function automatic logic [WIDTH:0] div_step(input logic [WIDTH:0]   r,
                                                 input logic             d,
                                                 input logic [WIDTH-1:0] m);
        logic [WIDTH+1:0] s;
        s = {r, d};
        if (s >= {2'b00, m})
            s = s - {2'b00, m};
        return (WIDTH+1)'(s);
    endfunction

    // acc never exceeds 3M-3, so one pass against 2M then M lands below M.
    function automatic logic [WIDTH+1:0] reduce_acc(input logic [WIDTH+1:0] x,
                                                    input logic [WIDTH-1:0] m);
        logic [WIDTH+1:0] m1;
        logic [WIDTH+1:0] m2;
        m1 = {2'b00, m};
        m2 = {1'b0, m, 1'b0};
        if (x >= m2)
            return x - m2;
        else if (x >= m1)
            return x - m1;
        else
            return x;
    endfunction

    assign rem_sub = div_step(rem, a_reg[WIDTH-1], m_reg);
    assign acc_mul = {acc[WIDTH:0], 1'b0} + (b_reg[WIDTH-1] ? {2'b00, a_reg} : '0);
    assign acc_mod = reduce_acc(acc, m_reg);

    assign is_multiplication_done = is_init_done && (bit_cnt == '0);

    always_comb begin
        phase_nxt        = phase;
        a_reg_nxt        = a_reg;
        b_reg_nxt        = b_reg;
        m_reg_nxt        = m_reg;
        rem_nxt          = rem;
        acc_nxt          = acc;
        bit_cnt_nxt      = bit_cnt;
        red_cnt_nxt      = red_cnt;
        init_done_nxt    = 1'b0;
        result_nxt       = result;
        result_valid_nxt = 1'b0;
        mod_error_nxt    = mod_error;

        case (phase)
            PH_IDLE: begin
                if (initialize) begin
                    a_reg_nxt   = op_a;
                    b_reg_nxt   = op_b;
                    m_reg_nxt   = op_m;
                    rem_nxt     = '0;
                    acc_nxt     = '0;
                    red_cnt_nxt = CNT_FULL;
                    if (op_m == '0) begin
                        mod_error_nxt = 1'b1;
                        bit_cnt_nxt   = '0;
                        phase_nxt     = PH_READY;
                    end else begin
                        mod_error_nxt = 1'b0;
                        bit_cnt_nxt   = CNT_FULL;
                        phase_nxt     = PH_REDUCE;
                    end
                end
            end

            PH_REDUCE: begin
                rem_nxt     = rem_sub;
                a_reg_nxt   = a_reg << 1;
                red_cnt_nxt = red_cnt - CNT_ONE;
                if (red_cnt == CNT_ONE) begin
                    a_reg_nxt = rem_sub[WIDTH-1:0];
                    phase_nxt = PH_READY;
                end
            end

            PH_READY: begin
                init_done_nxt = 1'b1;
                if (en_multiply) begin
                    if (bit_cnt != '0) begin
                        acc_nxt     = acc_mul;
                        b_reg_nxt   = b_reg << 1;
                        bit_cnt_nxt = bit_cnt - CNT_ONE;
                    end
                end else if (en_modulo) begin
                    acc_nxt = acc_mod;
                end
                if (done) begin
                    result_nxt       = mod_error ? '0 : acc[WIDTH-1:0];
                    result_valid_nxt = 1'b1;
                    init_done_nxt    = 1'b0;
                    phase_nxt        = PH_IDLE;
                end
            end

            default: phase_nxt = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase        <= PH_IDLE;
            a_reg        <= '0;
            b_reg        <= '0;
            m_reg        <= '0;
            rem          <= '0;
            acc          <= '0;
            bit_cnt      <= '0;
            red_cnt      <= '0;
            is_init_done <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            mod_error    <= 1'b0;
        end else begin
            phase        <= phase_nxt;
            a_reg        <= a_reg_nxt;
            b_reg        <= b_reg_nxt;
            m_reg        <= m_reg_nxt;
            rem          <= rem_nxt;
            acc          <= acc_nxt;
            bit_cnt      <= bit_cnt_nxt;
            red_cnt      <= red_cnt_nxt;
            is_init_done <= init_done_nxt;
            result       <= result_nxt;
            result_valid <= result_valid_nxt;
            mod_error    <= mod_error_nxt;
        end
    end

endmodule
